// File: rtl/elevator_core.sv
// elevator_core: four-floor elevator controller core.
// Latches hall/car calls into a pending-request register, tracks the car
// position from the floor sensors and drives motor, door and floor display
// from a registered Moore FSM.
// Optional build macro DOOR_HOLD_EN: while the door is open, holding any
// button of the current floor keeps reloading the door timer.
module elevator_core #(
    parameter int DOOR_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       S1,
    input  logic       S2,
    input  logic       S3,
    input  logic       S4,
    input  logic       U1,
    input  logic       U2,
    input  logic       U3,
    input  logic       U4,
    input  logic       D1,
    input  logic       D2,
    input  logic       D3,
    input  logic       D4,
    input  logic       F1,
    input  logic       F2,
    input  logic       F3,
    input  logic       F4,
    output logic       up,
    output logic       down,
    output logic       stop,
    output logic [1:0] monitor,
    output logic       open_door
);

    localparam int TW = (DOOR_CYCLES < 2) ? 1 : $clog2(DOOR_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN, DOOR} state_t;
    typedef enum logic {DIR_UP, DIR_DN} dir_t;

    state_t          state;
    dir_t            dir;
    logic [3:0]      req;        // bit i = pending request for floor i+1
    logic [1:0]      dep_floor;  // floor index the car left from
    logic [TW-1:0]   timer;

    logic [3:0]      sens;
    logic [3:0]      calls;
    logic            sens_any;
    logic [1:0]      sens_idx;
    logic            req_above;
    logic            req_below;
    logic            go_up;
    logic            go_dn;
    logic            door_hold;

    assign sens  = {S4, S3, S2, S1};
    assign calls = {U4 | D4 | F4, U3 | D3 | F3, U2 | D2 | F2, U1 | D1 | F1};

    // Decode sensors (lowest index wins) and find requests above/below the car.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        sens_any  = |sens;
        sens_idx  = 2'd0;
        req_above = 1'b0;
        req_below = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (sens[i]) sens_idx = 2'(i);
        end
        for (int i = 0; i < 4; i++) begin
            if (req[i] && (i > int'(monitor))) req_above = 1'b1;
            if (req[i] && (i < int'(monitor))) req_below = 1'b1;
        end
        // Keep travelling the last direction while it still has work.
        if (dir == DIR_UP) begin
            go_up = req_above;
            go_dn = !req_above && req_below;
        end else begin
            go_up = req_above && !req_below;
            go_dn = req_below;
        end
`ifdef DOOR_HOLD_EN
        door_hold = calls[monitor];
`else
        door_hold = 1'b0;
`endif
    end

    // Floor indicator: follows the sensors, holds between floors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            monitor <= 2'd0;
        end else if (sens_any) begin
            monitor <= sens_idx;
        end
    end

    // Main controller FSM with registered outputs and the request register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            dir       <= DIR_UP;
            req       <= 4'b0000;
            dep_floor <= 2'd0;
            timer     <= '0;
            up        <= 1'b0;
            down      <= 1'b0;
            stop      <= 1'b1;
            open_door <= 1'b0;
        end else begin
            // NOTE: non-blocking only here; a later assignment to req in this
            // block overrides this one, which is how clear beats set.
            req <= req | calls;
            case (state)
                IDLE: begin
                    if (req[monitor] && sens[monitor]) begin
                        state     <= DOOR;
                        open_door <= 1'b1;
                        timer     <= TW'(DOOR_CYCLES);
                        req       <= (req | calls) & ~(4'b0001 << monitor);
                    end else if (go_up) begin
                        state     <= MOVE_UP;
                        dir       <= DIR_UP;
                        dep_floor <= monitor;
                        up        <= 1'b1;
                        stop      <= 1'b0;
                    end else if (go_dn) begin
                        state     <= MOVE_DN;
                        dir       <= DIR_DN;
                        dep_floor <= monitor;
                        down      <= 1'b1;
                        stop      <= 1'b0;
                    end
                end
                MOVE_UP: begin
                    if (sens_any && (sens_idx > dep_floor)) begin
                        if (req[sens_idx]) begin
                            state     <= DOOR;
                            up        <= 1'b0;
                            stop      <= 1'b1;
                            open_door <= 1'b1;
                            timer     <= TW'(DOOR_CYCLES);
                            req       <= (req | calls) & ~(4'b0001 << sens_idx);
                        end else if (sens_idx == 2'd3) begin
                            state <= IDLE;
                            up    <= 1'b0;
                            stop  <= 1'b1;
                        end
                    end
                end
                MOVE_DN: begin
                    if (sens_any && (sens_idx < dep_floor)) begin
                        if (req[sens_idx]) begin
                            state     <= DOOR;
                            down      <= 1'b0;
                            stop      <= 1'b1;
                            open_door <= 1'b1;
                            timer     <= TW'(DOOR_CYCLES);
                            req       <= (req | calls) & ~(4'b0001 << sens_idx);
                        end else if (sens_idx == 2'd0) begin
                            state <= IDLE;
                            down  <= 1'b0;
                            stop  <= 1'b1;
                        end
                    end
                end
                DOOR: begin
                    if (door_hold) begin
                        timer <= TW'(DOOR_CYCLES);
                    end else if (timer <= TW'(1)) begin
                        state     <= IDLE;
                        open_door <= 1'b0;
                        timer     <= '0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_core.sv
// tb_elevator_core: directed scenario bench for elevator_core with an
// expected-output scoreboard; the bench plays the role of the shaft sensors.
module tb_elevator_core;

    logic       clk;
    logic       reset;
    logic       S1, S2, S3, S4;
    logic       U1, U2, U3, U4;
    logic       D1, D2, D3, D4;
    logic       F1, F2, F3, F4;
    logic       up, down, stop, open_door;
    logic [1:0] monitor;

    typedef struct {
        string      tag;
        logic       up;
        logic       down;
        logic       stop;
        logic       open_door;
        logic [1:0] monitor;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    elevator_core #(.DOOR_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .S1(S1), .S2(S2), .S3(S3), .S4(S4),
        .U1(U1), .U2(U2), .U3(U3), .U4(U4),
        .D1(D1), .D2(D2), .D3(D3), .D4(D4),
        .F1(F1), .F2(F2), .F3(F3), .F4(F4),
        .up(up), .down(down), .stop(stop),
        .monitor(monitor), .open_door(open_door)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_next();
        exp_t e;
        n_checks++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 required=1");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            assert (up === e.up) else begin
                n_fail++;
                $error("FAIL %s.up observed=%b required=%b", e.tag, up, e.up);
            end
            n_checks++;
            assert (down === e.down) else begin
                n_fail++;
                $error("FAIL %s.down observed=%b required=%b", e.tag, down, e.down);
            end
            n_checks++;
            assert (stop === e.stop) else begin
                n_fail++;
                $error("FAIL %s.stop observed=%b required=%b", e.tag, stop, e.stop);
            end
            n_checks++;
            assert (open_door === e.open_door) else begin
                n_fail++;
                $error("FAIL %s.open_door observed=%b required=%b", e.tag, open_door, e.open_door);
            end
            n_checks++;
            assert (monitor === e.monitor) else begin
                n_fail++;
                $error("FAIL %s.monitor observed=%0d required=%0d", e.tag, monitor, e.monitor);
            end
            n_checks++;
            assert ($onehot({up, down, stop})) else begin
                n_fail++;
                $error("FAIL %s.onehot observed=%b required=one-hot", e.tag, {up, down, stop});
            end
        end
    endtask

    // Push the expected outputs, let n clocks pass, then compare.
    task automatic step(input int n, input string tag, input logic u, input logic d,
                        input logic s, input logic o, input logic [1:0] m);
        exp_t e;
        e.tag = tag; e.up = u; e.down = d; e.stop = s; e.open_door = o; e.monitor = m;
        sb.push_back(e);
        if (n > 0) cyc(n);
        check_next();
    endtask

    initial begin
        reset = 1'b0;
        {S1, S2, S3, S4} = 4'b0000;
        {U1, U2, U3, U4} = 4'b0000;
        {D1, D2, D3, D4} = 4'b0000;
        {F1, F2, F3, F4} = 4'b0000;
        S1 = 1'b1;

        // Reset held for two clocks.
        step(2, "reset", 0, 0, 1, 0, 2'd0);

        // U2 held at floor 1: motor up two clocks after the button.
        reset = 1'b1;
        U2 = 1'b1;
        step(1, "u2_latch", 0, 0, 1, 0, 2'd0);
        step(1, "u2_up", 1, 0, 0, 0, 2'd0);
        U2 = 1'b0;
        S1 = 1'b0;
        step(3, "between_1_2", 1, 0, 0, 0, 2'd0);
        S2 = 1'b1;
        step(1, "arrive_2", 0, 0, 1, 1, 2'd1);
        step(1, "door_2_hold", 0, 0, 1, 1, 2'd1);
        step(1, "door_2_close", 0, 0, 1, 0, 2'd1);
        step(3, "idle_2_cleared", 0, 0, 1, 0, 2'd1);

        // F2 while idling at floor 2: door only, no motion.
        F2 = 1'b1;
        cyc(1);
        F2 = 1'b0;
        step(1, "f2_door", 0, 0, 1, 1, 2'd1);
        step(1, "f2_door_hold", 0, 0, 1, 1, 2'd1);
        step(1, "f2_close", 0, 0, 1, 0, 2'd1);
        step(3, "f2_cleared", 0, 0, 1, 0, 2'd1);

        // D4 pulsed at floor 2: pass floor 3, stop at 4.
        D4 = 1'b1;
        cyc(1);
        D4 = 1'b0;
        step(1, "d4_up", 1, 0, 0, 0, 2'd1);
        S2 = 1'b0;
        step(2, "between_2_3", 1, 0, 0, 0, 2'd1);
        S3 = 1'b1;
        step(1, "pass_3", 1, 0, 0, 0, 2'd2);
        S3 = 1'b0;
        step(2, "between_3_4", 1, 0, 0, 0, 2'd2);
        S4 = 1'b1;
        step(1, "arrive_4", 0, 0, 1, 1, 2'd3);
        step(2, "door_4_close", 0, 0, 1, 0, 2'd3);

        // F1+F3 together at floor 4 with dir=UP: reverse, stop at 3, then 1.
        F1 = 1'b1;
        F3 = 1'b1;
        cyc(1);
        F1 = 1'b0;
        F3 = 1'b0;
        step(1, "f1f3_down", 0, 1, 0, 0, 2'd3);
        S4 = 1'b0;
        step(2, "between_4_3", 0, 1, 0, 0, 2'd3);
        S3 = 1'b1;
        step(1, "arrive_3", 0, 0, 1, 1, 2'd2);
        step(2, "door_3_close", 0, 0, 1, 0, 2'd2);
        step(1, "resume_down", 0, 1, 0, 0, 2'd2);
        S3 = 1'b0;
        step(2, "between_3_2", 0, 1, 0, 0, 2'd2);
        S2 = 1'b1;
        step(1, "pass_2", 0, 1, 0, 0, 2'd1);
        S2 = 1'b0;
        cyc(1);
        S1 = 1'b1;
        step(1, "arrive_1", 0, 0, 1, 1, 2'd0);
        step(2, "door_1_close", 0, 0, 1, 0, 2'd0);
        step(3, "idle_1", 0, 0, 1, 0, 2'd0);

        // F3 from floor 1 with dir=DN: reverses up; then reset mid-move.
        F3 = 1'b1;
        cyc(1);
        F3 = 1'b0;
        step(1, "f3_up", 1, 0, 0, 0, 2'd0);
        #2;
        reset = 1'b0;
        #1;
        step(0, "async_reset", 0, 0, 1, 0, 2'd0);
        cyc(1);
        reset = 1'b1;
        step(4, "req_lost", 0, 0, 1, 0, 2'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/elevator_core.md
Name: elevator_core

Overview:
- Four-floor elevator controller core, floors 1..4.
- Latches hall calls (Ux/Dx) and car calls (Fx) into a pending-request register and tracks car position from the floor sensors S1..S4.
- Drives the motor (up/down/stop), the door (open_door) and the floor indicator (monitor) through a registered Moore FSM.
- Sits between the button/sensor input layer and the motor/door/display drivers.

Parameters:
- DOOR_CYCLES, 2, number of clock cycles open_door stays asserted per stop (minimum 1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- S1..S4  in  1 each  floor sensors; Sx=1 while the car is level with floor x; all 0 between floors.
- U1..U4  in  1 each  hall up-call buttons; U4 is accepted as a plain request for floor 4.
- D1..D4  in  1 each  hall down-call buttons; D1 is accepted as a plain request for floor 1.
- F1..F4  in  1 each  car-panel floor buttons.
- up  out  1  motor up command.
- down  out  1  motor down command.
- stop  out  1  motor stopped.
- monitor  out  2  current/last-passed floor, encoded as floor minus 1 (0 = floor 1 … 3 = floor 4).
- open_door  out  1  door open command.

Behaviour:
- All outputs registered. Exactly one of up/down/stop is 1 at all times.
- Reset values (async on reset=0): state IDLE; up=0, down=0, stop=1; open_door=0; monitor=0; req=0000; dir=UP; door timer=0.
- Request register req[4:1]:
  - req[x] sets on any clock where Ux|Dx|Fx=1.
  - req[x] clears on the clock that enters DOOR at floor x.
  - Clear wins over set on that single cycle. A button still held after that cycle re-sets req[x].
- Floor tracking:
  - On each clock where any Sx=1, monitor <= x-1. If several are high, the lowest index wins.
  - With all sensors 0, monitor holds its value.
- dir register holds the last travel direction, UP or DN.
- FSM states: IDLE, MOVE_UP, MOVE_DN, DOOR.
- IDLE (stop=1):
  - req[cur] set and S_cur=1 -> DOOR.
  - Else, if dir=UP: any request above cur -> MOVE_UP; else any request below -> MOVE_DN.
  - Else (dir=DN): any request below -> MOVE_DN; else any request above -> MOVE_UP.
  - No requests -> stay in IDLE.
- MOVE_UP (up=1, dir<=UP):
  - On a clock where Sk=1 for k > floor of departure and req[k]=1 -> DOOR at k.
  - Sk=1 with req[k]=0 -> keep moving; monitor updates.
  - S4=1 -> DOOR if req[4], else IDLE. The car never drives past floor 4.
- MOVE_DN: mirror of MOVE_UP (down=1, dir<=DN, floor-1 limit).
- DOOR (stop=1, open_door=1):
  - Timer loads DOOR_CYCLES on entry and decrements each clock.
  - At 0 -> IDLE with open_door=0.
  - Requests for other floors keep latching during DOOR.
- Latency: a request is visible in req one clock after the button. The FSM reacts on the following clock, so a motor output changes 2 clocks after the button edge.
- Simultaneous events:
  - A request at the current floor while in IDLE has priority over travel.
  - A new request arriving while moving is served if the car has not yet passed that floor in the current direction; otherwise it waits for direction reversal.
- Reset mid-operation: immediate return to the reset values. Pending requests are lost.

Optional Feature:
- Macro DOOR_HOLD_EN.
- Defined: while in DOOR, the car button or either hall button of the current floor being held reloads the timer to DOOR_CYCLES, keeping the door open until released.
- Undefined: the DOOR duration is fixed at DOOR_CYCLES regardless of buttons.

Test Plan:
- Reset: reset=0 for 2 clocks -> stop=1, up=0, down=0, open_door=0, monitor=0, req=0.
- Car at S1, U2 held -> up=1 within 2 clocks. All sensors 0: up stays 1. S2=1 -> stop=1, open_door=1 for 2 clocks, monitor=1, req[2] cleared.
- Car idle at S2, D4 pulsed 1 clock -> up=1. S3=1 -> up stays 1, monitor=2. S4=1 -> stop=1, open_door=1, monitor=3.
- Car at floor 4 with dir=UP, F1 and F3 pressed together -> down=1. Stops at S3 first (open_door, req[3] cleared), then continues down to S1.
- F2 pressed while the car idles at S2 -> no motion; open_door=1 for DOOR_CYCLES; req[2] cleared.
- Reset asserted while up=1 -> outputs return to reset values asynchronously, before the next clock edge.
